// File: rtl/mdu_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: opcodes, FSM encoding, default width.
// The divider is built only when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_OP_NOP   = 3'd0;
  localparam logic [2:0] MDU_OP_MULT  = 3'd1;
  localparam logic [2:0] MDU_OP_MULTU = 3'd2;
  localparam logic [2:0] MDU_OP_DIV   = 3'd3;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/hilo_mdu_if.sv
// E-stage interface between the pipeline (master) and the multiply/divide unit (slave).
interface hilo_mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  // validE qualifies mdu_opE/hilo_weE in the cycle it is high; there is no ready signal.
  // While stall_mdu is high the pipeline holds E; mdu_done pulses once when a divide result lands.
  logic             validE;
  logic [2:0]       mdu_opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic [1:0]       hilo_weE;
  logic             flushE;
  logic             stall_mdu;
  logic             mdu_done;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [1:0]       dbg_state;

  modport master (
    output validE, mdu_opE, srcaE, srcbE, hilo_weE, flushE,
    input  stall_mdu, mdu_done, hi_o, lo_o, dbg_state
  );

  modport slave (
    input  validE, mdu_opE, srcaE, srcbE, hilo_weE, flushE,
    output stall_mdu, mdu_done, hi_o, lo_o, dbg_state
  );
endinterface

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle after start_i.
// done_o is high during the final step; quo_o/rem_o then carry the finished result.
module mdu_div_core #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);
  localparam int CW = $clog2(ITERS + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted, diff;

  // The dividend shifts out of quo_q's top while quotient bits shift in at the bottom.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign done_o  = busy_q && (cnt_q == CW'(ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_o;
      rem_q <= rem_o;
      if (done_o) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit with HI/LO registers; single-cycle multiply, iterative divide.
// Divide support is compiled in only when MDU_DIV_EN is defined; otherwise DIV/DIVU act as NOP.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH     = MDU_WIDTH,
  parameter int DIV_ITERS = WIDTH
) (
  input logic       clk,
  input logic       rst,
  hilo_mdu_if.slave bus
);
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               act, is_mul, is_div;

  assign act    = bus.validE && !bus.flushE;
  assign is_mul = (bus.mdu_opE == MDU_OP_MULT) || (bus.mdu_opE == MDU_OP_MULTU);
  assign is_div = (bus.mdu_opE == MDU_OP_DIV) || (bus.mdu_opE == MDU_OP_DIVU);
  assign prod_s = $signed(bus.srcaE) * $signed(bus.srcbE);
  assign prod_u = {{WIDTH{1'b0}}, bus.srcaE} * {{WIDTH{1'b0}}, bus.srcbE};

`ifdef MDU_DIV_EN
  logic             start_div, signed_op, core_done;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH-1:0] abs_a, abs_b, core_quo, core_rem;

  assign start_div = (state_q == ST_IDLE) && act && is_div && (bus.srcbE != '0);
  assign signed_op = (bus.mdu_opE == MDU_OP_DIV);
  assign abs_a     = (signed_op && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
  assign abs_b     = (signed_op && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

  mdu_div_core #(.WIDTH(WIDTH), .ITERS(DIV_ITERS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_div),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .abort_i    ((state_q == ST_DIV) && bus.flushE),
    .quo_o      (core_quo),
    .rem_o      (core_rem),
    .done_o     (core_done)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (start_div) begin
      q_neg_q <= signed_op && (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
      r_neg_q <= signed_op && bus.srcaE[WIDTH-1];
    end
  end

  assign bus.stall_mdu = start_div || (state_q == ST_DIV);
  assign bus.mdu_done  = (state_q == ST_DONE);
`else
  assign bus.stall_mdu = 1'b0;
  assign bus.mdu_done  = 1'b0;
`endif

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (act) begin
          if (is_mul) begin
            {hi_d, lo_d} = (bus.mdu_opE == MDU_OP_MULT) ? prod_s : prod_u;
          end else if (is_div) begin
`ifdef MDU_DIV_EN
            if (bus.srcbE != '0) state_d = ST_DIV;
`endif
          end else begin
            if (bus.hilo_weE[1]) hi_d = bus.srcaE;
            if (bus.hilo_weE[0]) lo_d = bus.srcaE;
          end
        end
      end
`ifdef MDU_DIV_EN
      ST_DIV: begin
        if (bus.flushE) begin
          state_d = ST_IDLE;
        end else if (core_done) begin
          lo_d    = q_neg_q ? -core_quo : core_quo;
          hi_d    = r_neg_q ? -core_rem : core_rem;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      state_q <= state_d;
    end
  end

  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu; divide scenarios run when MDU_DIV_EN is defined, NOP checks otherwise.
module tb_hilo_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hilo_mdu_if #(.WIDTH(32)) bus ();

  hilo_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.validE   = 1'b0;
    bus.mdu_opE  = MDU_OP_NOP;
    bus.srcaE    = '0;
    bus.srcbE    = '0;
    bus.hilo_weE = 2'b00;
    bus.flushE   = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1. Issues one op in cycle 0, then runs 40 cycles.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int mul_at,
                         output int stall_cnt, output int done_cnt, output int done_cyc);
    stall_cnt = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      idle_inputs();
      if (cyc == 0) begin
        bus.validE = 1'b1; bus.mdu_opE = op; bus.srcaE = a; bus.srcbE = b;
      end
      if (cyc == flush_at) bus.flushE = 1'b1;
      if (cyc == mul_at) begin
        bus.validE = 1'b1; bus.mdu_opE = MDU_OP_MULT; bus.srcaE = 32'd3; bus.srcbE = 32'd5;
      end
      #1;
      if (bus.stall_mdu) stall_cnt++;
      if (bus.mdu_done) begin done_cnt++; done_cyc = cyc; end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic single_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] we, input logic flush, output logic stall_seen);
    bus.validE = 1'b1; bus.mdu_opE = op; bus.srcaE = a; bus.srcbE = b;
    bus.hilo_weE = we; bus.flushE = flush;
    #1;
    stall_seen = bus.stall_mdu;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo_o); end
    checks++; if (bus.stall_mdu !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_mdu); end
    checks++; if (bus.mdu_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.mdu_done); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic st;
    single_op(MDU_OP_MULT, 32'hFFFFFFFF, 32'd2, 2'b00, 1'b0, st);
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL mult_stall got=%b exp=0", st); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", bus.lo_o); end
    single_op(MDU_OP_MULTU, 32'hFFFFFFFF, 32'd2, 2'b00, 1'b0, st);
    checks++; if (bus.hi_o !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo_o); end
  endtask

  task automatic test_mthi_mtlo();
    logic st;
    single_op(MDU_OP_NOP, 32'h1234, 32'd0, 2'b10, 1'b0, st);
    checks++; if (bus.hi_o !== 32'h1234) begin failures++; $display("FAIL mthi_hi got=%h exp=00001234", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL mthi_lo_kept got=%h exp=fffffffe", bus.lo_o); end
    single_op(MDU_OP_NOP, 32'h5678, 32'd0, 2'b01, 1'b0, st);
    checks++; if (bus.hi_o !== 32'h1234) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=00001234", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'h5678) begin failures++; $display("FAIL mtlo_lo got=%h exp=00005678", bus.lo_o); end
  endtask

  task automatic test_priority_and_flush();
    logic st;
    single_op(MDU_OP_MULT, 32'd3, 32'd5, 2'b11, 1'b0, st);
    checks++; if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL mul_prio_hi got=%h exp=0", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'd15) begin failures++; $display("FAIL mul_prio_lo got=%h exp=0000000f", bus.lo_o); end
    single_op(MDU_OP_NOP, 32'hDEAD, 32'd0, 2'b11, 1'b1, st);
    checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'd15) begin
      failures++; $display("FAIL flush_idle_write got=%h_%h exp=00000000_0000000f", bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_div_by_zero();
    logic st;
    single_op(MDU_OP_DIVU, 32'd100, 32'd0, 2'b00, 1'b0, st);
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL divz_stall got=%b exp=0", st); end
    checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'd15) begin
      failures++; $display("FAIL divz_hilo got=%h_%h exp=00000000_0000000f", bus.hi_o, bus.lo_o); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL divz_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div_signed();
    int sc, dc, dcy;
    run_div(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, -1, -1, sc, dc, dcy);
    checks++; if (sc !== 33) begin failures++; $display("FAIL div_stall_cycles got=%0d exp=33", sc); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL div_done_pulses got=%0d exp=1", dc); end
    checks++; if (dcy !== 33) begin failures++; $display("FAIL div_done_cycle got=%0d exp=33", dcy); end
    checks++; if (bus.lo_o !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo_o); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi_o); end
    run_div(MDU_OP_DIV, 32'd7, 32'hFFFFFFFE, -1, -1, sc, dc, dcy);
    checks++; if (bus.lo_o !== 32'hFFFFFFFD || bus.hi_o !== 32'd1) begin
      failures++; $display("FAIL div_neg_divisor got=%h_%h exp=00000001_fffffffd", bus.hi_o, bus.lo_o); end
    run_div(MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, sc, dc, dcy);
    checks++; if (bus.lo_o !== 32'h80000000 || bus.hi_o !== 32'h0) begin
      failures++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_div_unsigned();
    int sc, dc, dcy;
    run_div(MDU_OP_DIVU, 32'hFFFFFFFF, 32'd2, -1, -1, sc, dc, dcy);
    checks++; if (bus.lo_o !== 32'h7FFFFFFF || bus.hi_o !== 32'd1) begin
      failures++; $display("FAIL divu_max got=%h_%h exp=00000001_7fffffff", bus.hi_o, bus.lo_o); end
    run_div(MDU_OP_DIVU, 32'd100, 32'd7, 10, -1, sc, dc, dcy);
    checks++; if (sc !== 11) begin failures++; $display("FAIL divu_flush_stall got=%0d exp=11", sc); end
    checks++; if (dc !== 0) begin failures++; $display("FAIL divu_flush_done got=%0d exp=0", dc); end
    checks++; if (bus.lo_o !== 32'h7FFFFFFF || bus.hi_o !== 32'd1) begin
      failures++; $display("FAIL divu_flush_hilo got=%h_%h exp=00000001_7fffffff", bus.hi_o, bus.lo_o); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL divu_flush_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); end
    // A MULT presented during the DONE cycle must not overwrite the quotient.
    run_div(MDU_OP_DIVU, 32'd100, 32'd7, -1, 33, sc, dc, dcy);
    checks++; if (sc !== 33 || dc !== 1) begin failures++; $display("FAIL divu_timing got=%0d/%0d exp=33/1", sc, dc); end
    checks++; if (bus.lo_o !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", bus.lo_o); end
    checks++; if (bus.hi_o !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", bus.hi_o); end
  endtask

  task automatic test_reset_mid_div();
    int dc = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      idle_inputs();
      if (cyc == 0) begin
        bus.validE = 1'b1; bus.mdu_opE = MDU_OP_DIVU; bus.srcaE = 32'd100; bus.srcbE = 32'd7;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      failures++; $display("FAIL rstdiv_hilo got=%h_%h exp=00000000_00000000", bus.hi_o, bus.lo_o); end
    checks++; if (bus.stall_mdu !== 1'b0) begin failures++; $display("FAIL rstdiv_stall got=%b exp=0", bus.stall_mdu); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL rstdiv_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); end
    @(posedge clk); #1 rst = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (bus.mdu_done) dc++;
    end
    checks++; if (dc !== 0 || bus.lo_o !== 32'h0 || bus.hi_o !== 32'h0) begin
      failures++; $display("FAIL rstdiv_after got=%0d_%h_%h exp=0_00000000_00000000", dc, bus.hi_o, bus.lo_o); end
  endtask
`else
  task automatic test_div_disabled();
    int sc, dc, dcy;
    run_div(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, -1, -1, sc, dc, dcy);
    checks++; if (sc !== 0) begin failures++; $display("FAIL nodiv_stall got=%0d exp=0", sc); end
    checks++; if (dc !== 0) begin failures++; $display("FAIL nodiv_done got=%0d exp=0", dc); end
    checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'd15) begin
      failures++; $display("FAIL nodiv_hilo got=%h_%h exp=00000000_0000000f", bus.hi_o, bus.lo_o); end
    run_div(MDU_OP_DIVU, 32'd100, 32'd7, -1, -1, sc, dc, dcy);
    checks++; if (sc !== 0 || dc !== 0 || bus.lo_o !== 32'd15 || bus.hi_o !== 32'h0) begin
      failures++; $display("FAIL nodivu got=%0d_%0d_%h_%h exp=0_0_00000000_0000000f", sc, dc, bus.hi_o, bus.lo_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_priority_and_flush();
    test_div_by_zero();
`ifdef MDU_DIV_EN
    test_div_signed();
    test_div_unsigned();
    test_reset_mid_div();
`else
    test_div_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
